// File: rtl/llsc_unit_pkg.sv
// ============================================================================
//  Module   : llsc_unit_pkg
//  Brief    : Shared opcode and state encodings for the LL/SC engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package llsc_unit_pkg;

    localparam logic [1:0] LLSC_OP_NONE = 2'd0;
    localparam logic [1:0] LLSC_OP_LL   = 2'd1;
    localparam logic [1:0] LLSC_OP_SC   = 2'd2;

    typedef enum logic [1:0] {
        LLSC_IDLE = 2'd0,
        LLSC_REQ  = 2'd1,
        LLSC_RESP = 2'd2
    } llsc_state_e;

endpackage

`default_nettype wire

// File: rtl/llsc_unit_link_reg.sv
// ============================================================================
//  Module   : llsc_unit_link_reg
//  Brief    : Link address register with two line comparators (SC check, snoop).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module llsc_unit_link_reg #(
    parameter int LINE_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_load_line,
    input  logic [LINE_W-1:0] i_sc_line,
    output logic              o_sc_hit,
    input  logic [LINE_W-1:0] i_snoop_line,
    output logic              o_snoop_hit
);

    logic [LINE_W-1:0] r_link;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link <= '0;
        end else if (i_load) begin
            r_link <= i_load_line;
        end
    end

    assign o_sc_hit    = (i_sc_line == r_link);
    assign o_snoop_hit = (i_snoop_line == r_link);

endmodule

`default_nettype wire

// File: rtl/llsc_unit.sv
// ============================================================================
//  Module   : llsc_unit
//  Brief    : MEM-stage LL/SC engine: runs LL/SC bus transactions, decides SC
//             success, snoops external writes and drives the LLbit write port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module llsc_unit
    import llsc_unit_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LINE_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              exc_flg_i,
    input  logic              eret_i,
    input  logic              atomicbit_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_ack_i,
    input  logic [DATA_W-1:0] dbus_rdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              sc_result_o,
    output logic              atomic_we_o,
    output logic              atomicbit_o
);

    localparam int c_WORD_LSB = 2;
    localparam int c_LINE_W   = ADDR_W - LINE_BITS;

    llsc_state_e                  r_state;
    logic                         r_req;
    logic                         r_we;
    logic                         r_is_ll;
    logic                         r_kill;
    logic                         r_done;
    logic                         r_sc_ok;
    logic [ADDR_W-1:c_WORD_LSB]   r_addr;
    logic [DATA_W-1:0]            r_wdata;
    logic [DATA_W-1:0]            r_rdata;

    logic w_op_act, w_accept, w_go_bus;
    logic w_sc_link_hit, w_snoop_link_hit, w_snoop_new_hit, w_snoop_hit;
    logic w_live, w_ll_commit, w_sc_commit;
    logic w_link_load, w_atomic_we, w_atomic_bit;
    logic w_unused;

    assign w_op_act = valid_i & (op_i != LLSC_OP_NONE);
    assign w_accept = (r_state == LLSC_IDLE) & w_op_act & ~exc_flg_i;
    assign w_go_bus = (op_i == LLSC_OP_LL) |
                      ((op_i == LLSC_OP_SC) & atomicbit_i & w_sc_link_hit);

    llsc_unit_link_reg #(
        .LINE_W (c_LINE_W)
    ) u_link (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_link_load),
        .i_load_line  (r_addr[ADDR_W-1:LINE_BITS]),
        .i_sc_line    (addr_i[ADDR_W-1:LINE_BITS]),
        .o_sc_hit     (w_sc_link_hit),
        .i_snoop_line (snoop_addr_i[ADDR_W-1:LINE_BITS]),
        .o_snoop_hit  (w_snoop_link_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LLSC_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_is_ll <= 1'b0;
            r_kill  <= 1'b0;
            r_done  <= 1'b0;
            r_sc_ok <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LLSC_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_accept) begin
                        r_addr  <= addr_i[ADDR_W-1:c_WORD_LSB];
                        r_wdata <= wdata_i;
                        r_is_ll <= (op_i == LLSC_OP_LL);
                        r_we    <= (op_i == LLSC_OP_SC) & w_go_bus;
                        if (w_go_bus) begin
                            r_req   <= 1'b1;
                            r_state <= LLSC_REQ;
                        end else begin
                            // failing SC skips the bus entirely
                            r_sc_ok <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= LLSC_RESP;
                        end
                    end
                end
                LLSC_REQ: begin
                    if (exc_flg_i) begin
                        r_kill <= 1'b1;
                    end
                    if (dbus_ack_i) begin
                        r_req   <= 1'b0;
                        r_sc_ok <= r_we;
                        r_done  <= 1'b1;
                        r_state <= LLSC_RESP;
                        if (!r_we) begin
                            r_rdata <= dbus_rdata_i;
                        end
                    end
                end
                default: r_state <= LLSC_IDLE;
            endcase
        end
    end

    // A flush seen in REQ or in RESP itself squashes completion and LLbit updates 3/4.
    assign w_live      = r_done & ~r_kill & ~exc_flg_i;
    assign w_ll_commit = w_live & r_is_ll;
    assign w_sc_commit = w_live & r_sc_ok;

    // While an LL commits, a snoop to the line being linked must also block the set.
    assign w_snoop_new_hit = (r_addr[ADDR_W-1:LINE_BITS] == snoop_addr_i[ADDR_W-1:LINE_BITS]);
    assign w_snoop_hit     = snoop_we_i & (w_snoop_link_hit | (w_ll_commit & w_snoop_new_hit));

    always_comb begin
        w_atomic_we  = 1'b0;
        w_atomic_bit = 1'b0;
        w_link_load  = 1'b0;
        if (w_snoop_hit || eret_i) begin
            w_atomic_we = 1'b1;
        end else if (w_ll_commit) begin
            w_atomic_we  = 1'b1;
            w_atomic_bit = 1'b1;
            w_link_load  = 1'b1;
        end else if (w_sc_commit) begin
            w_atomic_we = 1'b1;
        end
    end

    assign dbus_req_o   = r_req;
    assign dbus_we_o    = r_we;
    assign dbus_addr_o  = {r_addr, {c_WORD_LSB{1'b0}}};
    assign dbus_wdata_o = r_wdata;
    assign stall_o      = w_op_act & (r_state != LLSC_RESP);
    assign done_o       = w_live;
    assign rdata_o      = r_rdata;
    assign sc_result_o  = w_live & r_sc_ok;
    assign atomic_we_o  = w_atomic_we;
    assign atomicbit_o  = w_atomic_bit;

    assign w_unused = ^{addr_i[c_WORD_LSB-1:0], snoop_addr_i[LINE_BITS-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_llsc_unit.sv
// ============================================================================
//  Module   : tb_llsc_unit
//  Brief    : Self-checking bench for llsc_unit against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_llsc_unit;
    import llsc_unit_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LINE_BITS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i, exc_flg_i, eret_i, atomicbit_i, snoop_we_i, dbus_ack_i;
    logic [1:0]        op_i;
    logic [ADDR_W-1:0] addr_i, snoop_addr_i, dbus_addr_o;
    logic [DATA_W-1:0] wdata_i, dbus_rdata_i, dbus_wdata_o, rdata_o;
    logic              dbus_req_o, dbus_we_o, stall_o, done_o, sc_result_o;
    logic              atomic_we_o, atomicbit_o;

    llsc_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BITS(LINE_BITS)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .exc_flg_i(exc_flg_i), .eret_i(eret_i),
        .atomicbit_i(atomicbit_i), .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .sc_result_o(sc_result_o),
        .atomic_we_o(atomic_we_o), .atomicbit_o(atomicbit_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the LLbit register and link address should hold.
    logic [ADDR_W-1:0] m_link  = '0;
    logic              m_llbit = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic same_line(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a >> LINE_BITS) == (b >> LINE_BITS);
    endfunction

    // One idle cycle, optionally with ERET and/or an external write.
    task automatic idle_cycle(input logic eret, input logic snp_we, input logic [ADDR_W-1:0] snp);
        logic exp_we;
        @(negedge clk);
        valid_i = 1'b0; op_i = LLSC_OP_NONE; exc_flg_i = 1'b0; dbus_ack_i = 1'b0;
        eret_i = eret; snoop_we_i = snp_we; snoop_addr_i = snp; atomicbit_i = m_llbit;
        #1;
        exp_we = eret | (snp_we & same_line(snp, m_link));
        check_eq("idle_done", done_o, 0);
        check_eq("idle_req", dbus_req_o, 0);
        check_eq("idle_stall", stall_o, 0);
        check_eq("idle_atomic_we", atomic_we_o, exp_we);
        if (exp_we) begin
            check_eq("idle_atomicbit", atomicbit_o, 0);
            m_llbit = 1'b0;
        end
    endtask

    // snoop_sel: 0 none, 1 external write in the completion cycle, 2 in the first bus cycle.
    task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int delay, input int snoop_sel,
                          input logic [ADDR_W-1:0] snp, input logic exc_req);
        logic              bus, killed, hit, exp_we, exp_bit;
        logic [DATA_W-1:0] rd;
        killed = 1'b0;
        rd     = '0;
        bus    = (op == LLSC_OP_LL) || (m_llbit && same_line(addr, m_link));
        @(negedge clk);
        valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata; atomicbit_i = m_llbit;
        eret_i = 1'b0; snoop_we_i = 1'b0; exc_flg_i = 1'b0; dbus_ack_i = 1'b0;
        #1;
        check_eq("accept_stall", stall_o, 1);
        check_eq("accept_req", dbus_req_o, 0);
        check_eq("accept_done", done_o, 0);
        check_eq("accept_atomic_we", atomic_we_o, 0);
        if (bus) begin
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk);
                rd = $urandom;
                dbus_rdata_i = rd;
                dbus_ack_i   = (k == delay);
                exc_flg_i    = exc_req && (k == 0);
                snoop_we_i   = (snoop_sel == 2) && (k == 0);
                snoop_addr_i = snp;
                atomicbit_i  = m_llbit;
                #1;
                check_eq("req_active", dbus_req_o, 1);
                check_eq("req_we", dbus_we_o, op == LLSC_OP_SC);
                check_eq("req_addr", dbus_addr_o, {addr[ADDR_W-1:2], 2'b00});
                if (op == LLSC_OP_SC) check_eq("req_wdata", dbus_wdata_o, wdata);
                check_eq("req_stall", stall_o, 1);
                check_eq("req_done", done_o, 0);
                hit = snoop_we_i && same_line(snp, m_link);
                check_eq("req_atomic_we", atomic_we_o, hit);
                if (hit) begin
                    check_eq("req_atomicbit", atomicbit_o, 0);
                    m_llbit = 1'b0;
                end
                if (exc_flg_i) begin
                    killed  = 1'b1;
                    m_llbit = 1'b0;
                end
            end
        end
        @(negedge clk);
        dbus_ack_i = 1'b0; exc_flg_i = 1'b0; atomicbit_i = m_llbit;
        snoop_we_i = (snoop_sel == 1); snoop_addr_i = snp;
        #1;
        check_eq("resp_done", done_o, !killed);
        check_eq("resp_stall", stall_o, 0);
        check_eq("resp_req", dbus_req_o, 0);
        if (!killed && op == LLSC_OP_LL) check_eq("resp_rdata", rdata_o, rd);
        if (!killed) check_eq("resp_sc_result", sc_result_o, (op == LLSC_OP_SC) && bus);
        hit = snoop_we_i && (same_line(snp, m_link) ||
                             (!killed && op == LLSC_OP_LL && same_line(snp, addr)));
        exp_bit = 1'b0;
        if (hit)                                       exp_we = 1'b1;
        else if (!killed && op == LLSC_OP_LL) begin    exp_we = 1'b1; exp_bit = 1'b1; end
        else if (!killed && op == LLSC_OP_SC && bus)   exp_we = 1'b1;
        else                                           exp_we = 1'b0;
        check_eq("resp_atomic_we", atomic_we_o, exp_we);
        if (exp_we) begin
            check_eq("resp_atomicbit", atomicbit_o, exp_bit);
            m_llbit = exp_bit;
            if (exp_bit) m_link = addr;
        end
    endtask

    logic [ADDR_W-1:0] pool [4] = '{32'h100, 32'h104, 32'h200, 32'h300};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; op_i = LLSC_OP_NONE; addr_i = '0; wdata_i = '0;
        exc_flg_i = 1'b0; eret_i = 1'b0; atomicbit_i = 1'b0; snoop_we_i = 1'b0;
        snoop_addr_i = 32'hFFFF_0000; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req", dbus_req_o, 0);
        check_eq("rst_we", dbus_we_o, 0);
        check_eq("rst_addr", dbus_addr_o, 0);
        check_eq("rst_wdata", dbus_wdata_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_rdata", rdata_o, 0);
        check_eq("rst_sc_result", sc_result_o, 0);
        check_eq("rst_atomic_we", atomic_we_o, 0);
        check_eq("rst_stall", stall_o, 0);
        rst = 1'b0;
        idle_cycle(1'b0, 1'b0, 32'h0);

        // Basic LL, successful SC, mismatched SC
        run_op(LLSC_OP_LL, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        run_op(LLSC_OP_SC, 32'h100, 32'hA5, 0, 0, 32'h0, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        run_op(LLSC_OP_LL, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        run_op(LLSC_OP_SC, 32'h104, 32'h5A, 0, 0, 32'h0, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        // Snoop clears the link; same-cycle snoop blocks the LL set
        idle_cycle(1'b0, 1'b1, 32'h102);
        run_op(LLSC_OP_LL, 32'h100, 32'h0, 0, 1, 32'h100, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        // Slow SC with held request, then a flushed LL
        run_op(LLSC_OP_LL, 32'h104, 32'h0, 1, 0, 32'h0, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        run_op(LLSC_OP_SC, 32'h104, 32'hDEAD_BEEF, 5, 2, 32'h104, 1'b0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        run_op(LLSC_OP_LL, 32'h200, 32'h0, 2, 0, 32'h0, 1'b1);
        idle_cycle(1'b0, 1'b0, 32'h0);

        // An op flushed in IDLE is never accepted
        @(negedge clk);
        valid_i = 1'b1; op_i = LLSC_OP_LL; addr_i = 32'h300; exc_flg_i = 1'b1;
        m_llbit = 1'b0;
        idle_cycle(1'b0, 1'b0, 32'h0);

        // Async reset while the bus request is pending
        @(negedge clk);
        valid_i = 1'b1; op_i = LLSC_OP_LL; addr_i = 32'h200; exc_flg_i = 1'b0;
        @(negedge clk);
        #1;
        check_eq("prerst_req", dbus_req_o, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_req", dbus_req_o, 0);
        check_eq("midrst_done", done_o, 0);
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b0; m_link = '0; m_llbit = 1'b0;
        #1;
        check_eq("postrst_req", dbus_req_o, 0);
        idle_cycle(1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]        rop;
            logic [ADDR_W-1:0] raddr, rsnp;
            rop   = ($urandom_range(1, 0) == 1) ? LLSC_OP_LL : LLSC_OP_SC;
            raddr = pool[$urandom_range(3, 0)] + ADDR_W'($urandom_range(3, 0));
            rsnp  = pool[$urandom_range(3, 0)] + ADDR_W'($urandom_range(3, 0));
            run_op(rop, raddr, $urandom, $urandom_range(3, 0), $urandom_range(2, 0), rsnp,
                   $urandom_range(7, 0) == 0);
            idle_cycle($urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0,
                       pool[$urandom_range(3, 0)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
